// File: rtl/uart_frame_sequencer.sv
// uart_frame_sequencer
// Sits behind the UART byte receiver and turns a stream of bytes into
// decoded commands. A frame is SYNC, OP, A_lo, A_hi, B_lo, B_hi, CHK, where
// CHK is the XOR of the five payload bytes. A good frame is presented
// downstream under a valid/ready handshake. Bad checksums, inter-byte
// timeouts and bytes that arrive while a command is still pending each
// raise a one-cycle error pulse.
//
// Parameters:
//   SYNC_BYTE     header byte that opens a frame
//   TIMEOUT_CLKS  max clocks allowed between consecutive frame bytes
//   CNT_W         timeout counter width, must hold TIMEOUT_CLKS-1
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx_valid      one-cycle strobe, rx_byte holds a new byte
//   rx_byte       received byte
//   cmd_valid     decoded command pending, held until accepted
//   cmd_ready     downstream accepts the pending command
//   cmd_op        opcode
//   cmd_a         operand A
//   cmd_b         operand B
//   err_checksum  one-cycle pulse, checksum mismatch
//   err_timeout   one-cycle pulse, inter-byte timeout
//   err_overrun   one-cycle pulse, byte dropped while a command was pending
//   frames_ok     count of accepted good frames, wraps at 256

module uart_frame_sequencer #(
   parameter logic [7:0] SYNC_BYTE    = 8'hAA,
   parameter int         TIMEOUT_CLKS = 86800,
   parameter int         CNT_W        = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [7:0]  cmd_op,
   output logic [15:0] cmd_a,
   output logic [15:0] cmd_b,
   output logic        err_checksum,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic [7:0]  frames_ok
);

   // States are numbered in arrival order so the payload states can
   // simply advance by one per received byte.
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_OP   = 3'd1;
   localparam logic [2:0] S_A_LO = 3'd2;
   localparam logic [2:0] S_A_HI = 3'd3;
   localparam logic [2:0] S_B_LO = 3'd4;
   localparam logic [2:0] S_B_HI = 3'd5;
   localparam logic [2:0] S_CHK  = 3'd6;
   localparam logic [2:0] S_HOLD = 3'd7;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);

   logic [2:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       xor_acc;
   logic [7:0]       op_sh;
   logic [15:0]      a_sh;
   logic [15:0]      b_sh;

   logic in_frame;
   logic expired;

   // The timeout only applies while collecting bytes after the header.
   // An arriving byte always beats expiry on the same cycle.
   assign in_frame = (state != S_IDLE) && (state != S_HOLD);
   assign expired  = in_frame && !rx_valid && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         xor_acc      <= '0;
         op_sh        <= '0;
         a_sh         <= '0;
         b_sh         <= '0;
         cmd_valid    <= 1'b0;
         cmd_op       <= '0;
         cmd_a        <= '0;
         cmd_b        <= '0;
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
         frames_ok    <= '0;
      end else begin
         err_checksum <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;

         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                  state   <= S_OP;
                  xor_acc <= '0;
               end
            end

            S_OP, S_A_LO, S_A_HI, S_B_LO, S_B_HI: begin
               if (rx_valid) begin
                  cnt     <= '0;
                  xor_acc <= xor_acc ^ rx_byte;
                  state   <= state + 3'd1;
                  case (state)
                     S_OP:    op_sh      <= rx_byte;
                     S_A_LO:  a_sh[7:0]  <= rx_byte;
                     S_A_HI:  a_sh[15:8] <= rx_byte;
                     S_B_LO:  b_sh[7:0]  <= rx_byte;
                     default: b_sh[15:8] <= rx_byte;
                  endcase
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  cnt         <= '0;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Checksum byte: publish the shadows only when it matches, so
            // a bad frame never disturbs the last good command on cmd_*.
            S_CHK: begin
               if (rx_valid) begin
                  cnt <= '0;
                  if (rx_byte == xor_acc) begin
                     cmd_op    <= op_sh;
                     cmd_a     <= a_sh;
                     cmd_b     <= b_sh;
                     cmd_valid <= 1'b1;
                     state     <= S_HOLD;
                  end else begin
                     err_checksum <= 1'b1;
                     state        <= S_IDLE;
                  end
               end else if (expired) begin
                  err_timeout <= 1'b1;
                  cnt         <= '0;
                  state       <= S_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Waiting for the downstream to take the command. A byte that
            // lands on the accepting edge is treated as if we were already
            // idle, so a header there starts the next frame immediately.
            S_HOLD: begin
               cnt <= '0;
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  frames_ok <= frames_ok + 8'd1;
                  if (rx_valid && (rx_byte == SYNC_BYTE)) begin
                     state   <= S_OP;
                     xor_acc <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (rx_valid) begin
                  err_overrun <= 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// tb_uart_frame_sequencer
// Directed bench for uart_frame_sequencer. Stimulus tasks push the expected
// command into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever a handshake transfer is about to happen, and counts
// error pulses so the stimulus side can compare totals at checkpoints.

module tb_uart_frame_sequencer;

   localparam int         TO   = 40;
   localparam int         CW   = 6;
   localparam logic [7:0] SYNC = 8'hAA;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
   logic        err_checksum;
   logic        err_timeout;
   logic        err_overrun;
   logic [7:0]  frames_ok;

   int total = 0;
   int bad   = 0;

   logic [39:0] expq[$];
   logic [7:0]  exp_frames = 8'd0;
   int n_chk = 0, n_to = 0, n_ov = 0;
   int exp_chk = 0, exp_to = 0, exp_ov = 0;

   always #5 clk = ~clk;

   uart_frame_sequencer #(
      .SYNC_BYTE(SYNC),
      .TIMEOUT_CLKS(TO),
      .CNT_W(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_valid(rx_valid),
      .rx_byte(rx_byte),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_op(cmd_op),
      .cmd_a(cmd_a),
      .cmd_b(cmd_b),
      .err_checksum(err_checksum),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun),
      .frames_ok(frames_ok)
   );

   task automatic checkOutput(input string name, input logic [39:0] actual,
                              input logic [39:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] frameChk(input logic [7:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      return op ^ a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8];
   endfunction

   // Called #1 after a rising edge; the byte is sampled on the next edge
   // and the task returns #1 after it, so consecutive calls are back-to-back.
   task automatic applyStimulus(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Payload and checksum without the header. A good frame is pushed to
   // the scoreboard before its checksum byte goes out.
   task automatic sendBody(input logic [7:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [7:0] chk,
                           input bit good);
      applyStimulus(op);
      applyStimulus(a[7:0]);
      applyStimulus(a[15:8]);
      applyStimulus(b[7:0]);
      applyStimulus(b[15:8]);
      if (good) expq.push_back({op, a, b});
      applyStimulus(chk);
      if (good) begin
         checkOutput("cmd_valid_latency", cmd_valid, 1);
      end else begin
         exp_chk++;
         checkOutput("err_checksum_pulse", err_checksum, 1);
         checkOutput("cmd_valid_after_bad", cmd_valid, 0);
      end
   endtask

   task automatic sendFrame(input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [7:0] chk,
                            input bit good);
      applyStimulus(SYNC);
      sendBody(op, a, b, chk, good);
   endtask

   task automatic printSummary();
      $display("test done: total=%0d bad=%0d", total, bad);
   endtask

   // Monitor: a transfer happens on the next rising edge whenever valid and
   // ready are both high mid-cycle, so that is where the scoreboard pops.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (cmd_valid && cmd_ready) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL cmd_unexpected: got %0h expected none",
                        {cmd_op, cmd_a, cmd_b});
            end else begin
               checkOutput("cmd_fields", {cmd_op, cmd_a, cmd_b}, expq.pop_front());
               exp_frames = exp_frames + 8'd1;
            end
         end
         if (err_checksum) n_chk++;
         if (err_timeout)  n_to++;
         if (err_overrun)  n_ov++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      bad++;
      printSummary();
      $finish;
   end

   initial begin
      rst_n     = 1'b0;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      cmd_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] reset state");
      checkOutput("reset_cmd", {cmd_valid, cmd_op, cmd_a, cmd_b}, 0);
      checkOutput("reset_err", {err_checksum, err_timeout, err_overrun}, 0);
      checkOutput("reset_frames", frames_ok, 0);

      // Good frame, ready held high. 03^34^12^78^56 = 0B.
      $display("[TB] good frame");
      cmd_ready = 1'b1;
      sendFrame(8'h03, 16'h1234, 16'h5678, 8'h0B, 1'b1);
      idle(1);
      checkOutput("cmd_valid_drop", cmd_valid, 0);
      checkOutput("frames_after_first", frames_ok, 1);

      // Same frame with a wrong checksum, then a fresh good frame.
      // A5^EF^BE^02^01 = F7.
      $display("[TB] checksum error");
      sendFrame(8'h03, 16'h1234, 16'h5678, 8'h00, 1'b0);
      idle(1);
      checkOutput("err_checksum_width", err_checksum, 0);
      checkOutput("frames_after_bad", frames_ok, 1);
      sendFrame(8'hA5, 16'hBEEF, 16'h0102, 8'hF7, 1'b1);
      idle(1);
      checkOutput("frames_after_recover", frames_ok, 2);

      // Timeout: last byte edge clears the counter, expiry lands TO edges later.
      // 11^33^22^55^44 = 11.
      $display("[TB] timeout");
      applyStimulus(SYNC);
      applyStimulus(8'h03);
      applyStimulus(8'h34);
      idle(TO - 1);
      checkOutput("timeout_early", err_timeout, 0);
      idle(1);
      exp_to++;
      checkOutput("timeout_pulse", err_timeout, 1);
      idle(1);
      checkOutput("timeout_width", err_timeout, 0);
      sendFrame(8'h11, 16'h2233, 16'h4455, 8'h11, 1'b1);
      idle(1);

      // A byte arriving on the expiry cycle keeps the frame alive.
      $display("[TB] byte on expiry cycle");
      applyStimulus(SYNC);
      applyStimulus(8'h03);
      applyStimulus(8'h34);
      idle(TO - 1);
      applyStimulus(8'h12);
      applyStimulus(8'h78);
      applyStimulus(8'h56);
      expq.push_back({8'h03, 16'h1234, 16'h5678});
      applyStimulus(8'h0B);
      checkOutput("expiry_cmd_valid", cmd_valid, 1);
      idle(1);
      checkOutput("expiry_no_timeout", n_to, exp_to);

      // Overrun while pending; 5A^FE^CA^57^13 = 2A.
      $display("[TB] overrun");
      cmd_ready = 1'b0;
      sendFrame(8'h5A, 16'hCAFE, 16'h1357, 8'h2A, 1'b1);
      idle(2);
      applyStimulus(8'h11);
      idle(2);
      applyStimulus(SYNC);
      idle(2);
      exp_ov += 2;
      checkOutput("overrun_count", n_ov, exp_ov);
      checkOutput("overrun_hold", {cmd_valid, cmd_op, cmd_a, cmd_b},
                  {1'b1, 8'h5A, 16'hCAFE, 16'h1357});
      // Accept coincident with a header byte: no overrun, next frame starts.
      // 77^01^00^00^80 = F6.
      cmd_ready = 1'b1;
      applyStimulus(SYNC);
      sendBody(8'h77, 16'h0001, 16'h8000, 8'hF6, 1'b1);
      idle(1);
      checkOutput("accept_no_overrun", n_ov, exp_ov);
      checkOutput("frames_after_overrun", frames_ok, exp_frames);

      // Junk in idle is ignored; reset mid-frame clears everything at once.
      $display("[TB] idle junk and async reset");
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      idle(2);
      checkOutput("junk_no_err", {n_chk, n_to, n_ov}, {exp_chk, exp_to, exp_ov});
      checkOutput("junk_no_cmd", cmd_valid, 0);
      applyStimulus(SYNC);
      applyStimulus(8'h03);
      applyStimulus(8'h34);
      applyStimulus(8'h12);
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_cmd", {cmd_valid, cmd_op, cmd_a, cmd_b}, 0);
      checkOutput("async_reset_misc",
                  {err_checksum, err_timeout, err_overrun, frames_ok}, 0);
      expq.delete();
      exp_frames = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sendFrame(8'h03, 16'h1234, 16'h5678, 8'h0B, 1'b1);
      idle(1);
      checkOutput("frames_after_reset", frames_ok, 1);

      // 255 more good frames bring the counter from 1 around to 0.
      $display("[TB] frame counter wrap");
      for (int i = 0; i < 255; i++) begin
         logic [7:0]  op;
         logic [15:0] a;
         logic [15:0] b;
         op = 8'(i);
         a  = {8'(i), ~8'(i)};
         b  = 16'(i * 3 + 16'h0100);
         sendFrame(op, a, b, frameChk(op, a, b), 1'b1);
      end
      idle(1);
      checkOutput("frames_wrap", frames_ok, 0);

      idle(2);
      checkOutput("scoreboard_empty", expq.size(), 0);
      checkOutput("checksum_total", n_chk, exp_chk);
      checkOutput("timeout_total", n_to, exp_to);
      checkOutput("overrun_total", n_ov, exp_ov);

      printSummary();
      $finish;
   end

endmodule
